hash_arbiter_2to1: RTL and testbench
====================================

Name: hash_arbiter_2to1

Overview:
Shares the single SHAKE hash core between two requesters, e.g. the sibling-path tree expander and the commitment generator in verify. Each requester issues a start pulse and drives the core through its usual hash interface: input buffer read, squeezed output with valid/ready, and force_done with ack. The arbiter queues the start pulses, grants the core round-robin for one whole session, and muxes all core signals to the granted requester.

Parameters:
- ADDR_W, 4: width of the core's input-buffer word address, CLOG2((SALT_SIZE+SEED_SIZE)/32).
- DATA_W, 32: hash data word width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_hash_start  in  2  per-requester start pulse; bit k is requester k
- i_req_input_length  in  64  per-requester input length in bits; [32k+31:32k]
- i_req_output_length  in  64  per-requester output length in bits
- i_req_hash_data_in  in  2*DATA_W  per-requester input-buffer read data
- i_req_hash_data_out_ready  in  2  per-requester output ready
- i_req_hash_force_done  in  2  per-requester force_done
- o_req_hash_addr  out  ADDR_W  core read address, broadcast to both requesters
- o_req_hash_rd_en  out  2  core read enable, gated to the granted requester
- o_req_hash_data_out  out  DATA_W  core output data, broadcast
- o_req_hash_data_out_valid  out  2  output valid, gated to the granted requester
- o_req_hash_force_done_ack  out  2  force_done ack, gated to the granted requester
- o_grant  out  2  one-hot grant, all-zero when the core is unowned
- o_hash_start  out  1  core start
- o_hash_input_length  out  32  core input length
- o_hash_output_length  out  32  core output length
- i_hash_addr  in  ADDR_W  core read address
- i_hash_rd_en  in  1  core read enable
- o_hash_data_in  out  DATA_W  core input data
- i_hash_data_out  in  DATA_W  core output data
- i_hash_data_out_valid  in  1  core output valid
- o_hash_data_out_ready  out  1  core output ready
- o_hash_force_done  out  1  core force_done
- i_hash_force_done_ack  in  1  core force_done ack

Behaviour:
- Internal registers:
  - pending[1:0]: bit k sets on i_req_hash_start[k] in any state; it clears only when requester k is granted.
  - g: index of the granted requester.
  - last: index of the last requester served.
  - len_in, len_out: 32-bit session lengths.
- Reset: state S_IDLE; pending=0; last=1, so requester 0 wins the first tie; o_grant=0. All outputs are 0 except the broadcast o_req_hash_addr and o_req_hash_data_out, which pass the core's signals through.
- S_IDLE:
  - The request set is req = pending | i_req_hash_start.
  - If exactly one bit is set, grant that requester. If both are set, grant !last.
  - On grant: register g, load len_in and len_out from slice g, clear pending[g], and go to S_START.
  - A start pulse consumed by the grant does not leave pending set.
- S_START: o_hash_start=1 for exactly one cycle; go to S_BUSY.
- Latency: a start pulse at cycle n in S_IDLE gives o_hash_start high at n+1.
- Grant visibility: o_grant[g]=1 throughout S_START and S_BUSY. o_hash_input_length and o_hash_output_length equal len_in and len_out from S_START through S_BUSY, and 0 otherwise.
- S_BUSY muxing, all combinational:
  - o_hash_data_in = i_req_hash_data_in slice g.
  - o_req_hash_rd_en[g] = i_hash_rd_en.
  - o_req_hash_data_out_valid[g] = i_hash_data_out_valid.
  - o_hash_data_out_ready = i_req_hash_data_out_ready[g].
  - o_hash_force_done = i_req_hash_force_done[g].
  - o_req_hash_force_done_ack[g] = i_hash_force_done_ack.
- Outside S_BUSY: o_hash_data_out_ready and o_hash_force_done are 0.
- Non-granted requester: its rd_en, valid and ack are always 0. Its force_done is ignored; its start pulse is only latched into pending.
- Session end: i_hash_force_done_ack in S_BUSY moves to S_RELEASE.
- S_RELEASE: o_grant=0, last<=g, go to S_IDLE.
- Handover: with a request pending, ack at cycle t gives o_hash_start at t+3.
- Re-issue: a start from the granted requester during its session (including the ack cycle) is latched in pending. It is then arbitrated normally, so an already pending other requester wins the handover.
- Reset mid-session: return to S_IDLE with pending cleared. The core must be reset by its own owner.

Test Plan:
- Single session: reset; r0 start pulse at cycle 10 with lengths 384 and 256 → o_hash_start at 11 with lengths 384/256, o_grant=01. Core valid/ready and rd_en reach r0 only; r0 force_done → ack to r0 → o_grant=00 at ack+1.
- Tie after reset: both starts in the same cycle → r0 served first. After r0's ack, r1's o_hash_start comes at ack+3. A following tie → r0 served.
- Queued request: r1 pulses at cycle 20 while r0 is busy → pending[1]=1, r1 gets no valid or ack; r1 starts at r0 ack+3.
- Re-issue competition: r0 re-pulses start in its ack cycle while r1 is pending → r1 granted next, r0 after r1's ack.
- Isolation: r1 asserts force_done while r0 is granted → o_hash_force_done stays 0, o_req_hash_force_done_ack[1]=0.
- Reset mid-session: i_rst in S_BUSY with r1 pending → next cycle o_grant=00, o_hash_start=0, pending=00, and no grant without a new start.

Source files
------------

// File: rtl/hash_arbiter_2to1.sv
// Two-requester arbiter for the shared SHAKE core. Start pulses are queued, the core is granted
// round-robin for a full session, and all core handshakes are muxed to the owner.
module hash_arbiter_2to1 #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [1:0]          i_req_hash_start,
   input  logic [63:0]         i_req_input_length,
   input  logic [63:0]         i_req_output_length,
   input  logic [2*DATA_W-1:0] i_req_hash_data_in,
   input  logic [1:0]          i_req_hash_data_out_ready,
   input  logic [1:0]          i_req_hash_force_done,
   output logic [ADDR_W-1:0]   o_req_hash_addr,
   output logic [1:0]          o_req_hash_rd_en,
   output logic [DATA_W-1:0]   o_req_hash_data_out,
   output logic [1:0]          o_req_hash_data_out_valid,
   output logic [1:0]          o_req_hash_force_done_ack,
   output logic [1:0]          o_grant,
   output logic                o_hash_start,
   output logic [31:0]         o_hash_input_length,
   output logic [31:0]         o_hash_output_length,
   input  logic [ADDR_W-1:0]   i_hash_addr,
   input  logic                i_hash_rd_en,
   output logic [DATA_W-1:0]   o_hash_data_in,
   input  logic [DATA_W-1:0]   i_hash_data_out,
   input  logic                i_hash_data_out_valid,
   output logic                o_hash_data_out_ready,
   output logic                o_hash_force_done,
   input  logic                i_hash_force_done_ack
);

   typedef enum logic [1:0] {StIdle, StStart, StBusy, StRelease} state_e;

   state_e      state_q, state_d;
   logic [1:0]  pending_q, pending_d;
   logic        g_q, g_d;
   logic        last_q, last_d;
   logic [31:0] len_in_q, len_in_d;
   logic [31:0] len_out_q, len_out_d;

   logic [1:0]  req;
   logic        gnt;
   logic        owned;
   logic        busy;
   logic [1:0]  sel;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         pending_q <= 2'b00;
         g_q       <= 1'b0;
         last_q    <= 1'b1;
         len_in_q  <= 32'd0;
         len_out_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         g_q       <= g_d;
         last_q    <= last_d;
         len_in_q  <= len_in_d;
         len_out_q <= len_out_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | i_req_hash_start;
      g_d       = g_q;
      last_d    = last_q;
      len_in_d  = len_in_q;
      len_out_d = len_out_q;
      req       = pending_q | i_req_hash_start;
      // On a tie the requester not served last wins; otherwise the lone requester.
      gnt       = (req == 2'b11) ? ~last_q : req[1];
      unique case (state_q)
         StIdle: begin
            if (req != 2'b00) begin
               g_d            = gnt;
               len_in_d       = gnt ? i_req_input_length[63:32] : i_req_input_length[31:0];
               len_out_d      = gnt ? i_req_output_length[63:32] : i_req_output_length[31:0];
               pending_d[gnt] = 1'b0;
               state_d        = StStart;
            end
         end
         StStart: state_d = StBusy;
         StBusy: begin
            if (i_hash_force_done_ack) state_d = StRelease;
         end
         StRelease: begin
            last_d  = g_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      owned = (state_q == StStart) || (state_q == StBusy);
      busy  = (state_q == StBusy);
      sel   = g_q ? 2'b10 : 2'b01;

      o_req_hash_addr      = i_hash_addr;
      o_req_hash_data_out  = i_hash_data_out;
      o_grant              = owned ? sel : 2'b00;
      o_hash_start         = (state_q == StStart);
      o_hash_input_length  = owned ? len_in_q : 32'd0;
      o_hash_output_length = owned ? len_out_q : 32'd0;

      o_req_hash_rd_en          = (busy && i_hash_rd_en) ? sel : 2'b00;
      o_req_hash_data_out_valid = (busy && i_hash_data_out_valid) ? sel : 2'b00;
      o_req_hash_force_done_ack = (busy && i_hash_force_done_ack) ? sel : 2'b00;
      o_hash_data_in            = '0;
      o_hash_data_out_ready     = 1'b0;
      o_hash_force_done         = 1'b0;
      if (busy) begin
         o_hash_data_in        = g_q ? i_req_hash_data_in[2*DATA_W-1:DATA_W]
                                     : i_req_hash_data_in[DATA_W-1:0];
         o_hash_data_out_ready = i_req_hash_data_out_ready[g_q];
         o_hash_force_done     = i_req_hash_force_done[g_q];
      end
   end

endmodule

// File: tb/tb_hash_arbiter_2to1.sv
// Bench for hash_arbiter_2to1: directed session/handover/reset scenarios, then random traffic
// compared cycle by cycle against a session-level reference model.
module tb_hash_arbiter_2to1;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_start;
   logic [63:0]       req_in_len;
   logic [63:0]       req_out_len;
   logic [63:0]       req_data_in;
   logic [1:0]        req_ready;
   logic [1:0]        req_fd;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_rd_en;
   logic [DATA_W-1:0] req_data_out;
   logic [1:0]        req_valid;
   logic [1:0]        req_ack;
   logic [1:0]        grant;
   logic              hash_start;
   logic [31:0]       hash_in_len;
   logic [31:0]       hash_out_len;
   logic [ADDR_W-1:0] core_addr;
   logic              core_rd_en;
   logic [DATA_W-1:0] hash_data_in;
   logic [DATA_W-1:0] core_data_out;
   logic              core_valid;
   logic              hash_ready;
   logic              hash_fd;
   logic              core_ack;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the core and where in its session it is.
   int          m_owner;   // -1 when no session
   bit          m_started; // start pulse already issued
   bit          m_rel;     // release cycle after ack
   bit   [1:0]  m_pend;
   int          m_last;
   logic [31:0] m_in;
   logic [31:0] m_out;

   always #5 clk = ~clk;

   hash_arbiter_2to1 #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .i_clk                     (clk),
      .i_rst                     (rst),
      .i_req_hash_start          (req_start),
      .i_req_input_length        (req_in_len),
      .i_req_output_length       (req_out_len),
      .i_req_hash_data_in        (req_data_in),
      .i_req_hash_data_out_ready (req_ready),
      .i_req_hash_force_done     (req_fd),
      .o_req_hash_addr           (req_addr),
      .o_req_hash_rd_en          (req_rd_en),
      .o_req_hash_data_out       (req_data_out),
      .o_req_hash_data_out_valid (req_valid),
      .o_req_hash_force_done_ack (req_ack),
      .o_grant                   (grant),
      .o_hash_start              (hash_start),
      .o_hash_input_length       (hash_in_len),
      .o_hash_output_length      (hash_out_len),
      .i_hash_addr               (core_addr),
      .i_hash_rd_en              (core_rd_en),
      .o_hash_data_in            (hash_data_in),
      .i_hash_data_out           (core_data_out),
      .i_hash_data_out_valid     (core_valid),
      .o_hash_data_out_ready     (hash_ready),
      .o_hash_force_done         (hash_fd),
      .i_hash_force_done_ack     (core_ack)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic quiet_inputs();
      req_start   = 2'b00;
      req_ready   = 2'b00;
      req_fd      = 2'b00;
      core_rd_en  = 1'b0;
      core_valid  = 1'b0;
      core_ack    = 1'b0;
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_started = 1'b0;
      m_rel     = 1'b0;
      m_pend    = 2'b00;
      m_last    = 1;
      m_in      = '0;
      m_out     = '0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      bit [1:0] req;
      if (rst) begin
         model_reset();
      end else if (m_rel) begin
         m_last  = m_owner;
         m_owner = -1;
         m_rel   = 1'b0;
         m_pend  = m_pend | req_start;
      end else if (m_owner >= 0) begin
         m_pend = m_pend | req_start;
         if (!m_started) m_started = 1'b1;
         else if (core_ack) m_rel = 1'b1;
      end else begin
         req = m_pend | req_start;
         if (req != 2'b00) begin
            if (req == 2'b11) m_owner = 1 - m_last;
            else m_owner = req[1] ? 1 : 0;
            m_started = 1'b0;
            m_in      = req_in_len[32*m_owner +: 32];
            m_out     = req_out_len[32*m_owner +: 32];
            m_pend    = req;
            m_pend[m_owner] = 1'b0;
         end
      end
   endtask

   task automatic model_compare();
      bit         own;
      bit         busy;
      logic [1:0] oh;
      own  = (m_owner >= 0) && !m_rel;
      busy = own && m_started;
      oh   = (m_owner == 1) ? 2'b10 : 2'b01;
      check("grant", 64'(grant), own ? 64'(oh) : 64'd0);
      check("hash_start", 64'(hash_start), 64'(own && !m_started));
      check("in_len", 64'(hash_in_len), own ? 64'(m_in) : 64'd0);
      check("out_len", 64'(hash_out_len), own ? 64'(m_out) : 64'd0);
      check("addr_bcast", 64'(req_addr), 64'(core_addr));
      check("data_out_bcast", 64'(req_data_out), 64'(core_data_out));
      check("rd_en", 64'(req_rd_en), (busy && core_rd_en) ? 64'(oh) : 64'd0);
      check("valid", 64'(req_valid), (busy && core_valid) ? 64'(oh) : 64'd0);
      check("ack", 64'(req_ack), (busy && core_ack) ? 64'(oh) : 64'd0);
      check("data_in", 64'(hash_data_in), busy ? 64'(req_data_in[32*m_owner +: 32]) : 64'd0);
      check("ready", 64'(hash_ready), busy ? 64'(req_ready[m_owner]) : 64'd0);
      check("force_done", 64'(hash_fd), busy ? 64'(req_fd[m_owner]) : 64'd0);
   endtask

   initial begin
      rst         = 1'b1;
      quiet_inputs();
      req_in_len  = {32'd512, 32'd384};
      req_out_len = {32'd128, 32'd256};
      req_data_in = {32'hB1B1_0001, 32'hA0A0_0000};
      core_addr     = 4'h5;
      core_data_out = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_start", 64'(hash_start), 64'd0);
      check("rst_in_len", 64'(hash_in_len), 64'd0);
      check("rst_addr", 64'(req_addr), 64'h5);
      check("rst_data_out", 64'(req_data_out), 64'hDEAD_BEEF);

      // Tie right after reset: r0 wins.
      @(negedge clk) req_start = 2'b11;
      @(negedge clk) req_start = 2'b00;
      #1;
      check("tie_start", 64'(hash_start), 64'd1);
      check("tie_grant", 64'(grant), 64'b01);
      check("tie_in_len", 64'(hash_in_len), 64'd384);
      check("tie_out_len", 64'(hash_out_len), 64'd256);

      // Busy with r0: core signals reach r0 only, r1 force_done is ignored.
      @(negedge clk);
      core_rd_en = 1'b1; core_valid = 1'b1; req_fd = 2'b10; req_ready = 2'b10;
      #1;
      check("iso_rd_en", 64'(req_rd_en), 64'b01);
      check("iso_valid", 64'(req_valid), 64'b01);
      check("iso_ready", 64'(hash_ready), 64'd0);
      check("iso_fd", 64'(hash_fd), 64'd0);
      check("iso_data_in", 64'(hash_data_in), 64'hA0A0_0000);
      req_ready = 2'b01; req_fd = 2'b11; core_ack = 1'b1; req_start = 2'b01;
      #1;
      check("r0_ready", 64'(hash_ready), 64'd1);
      check("r0_fd", 64'(hash_fd), 64'd1);
      check("r0_ack", 64'(req_ack), 64'b01);

      // Handover to pending r1 at ack+3, r0 re-issued in its ack cycle.
      @(negedge clk) quiet_inputs();
      #1 check("rel_grant", 64'(grant), 64'd0);
      @(negedge clk) #1 check("idle_start", 64'(hash_start), 64'd0);
      @(negedge clk) #1;
      check("r1_start", 64'(hash_start), 64'd1);
      check("r1_grant", 64'(grant), 64'b10);
      check("r1_in_len", 64'(hash_in_len), 64'd512);
      @(negedge clk) core_ack = 1'b1;
      #1 check("r1_ack", 64'(req_ack), 64'b10);
      @(negedge clk) quiet_inputs();
      @(negedge clk);
      @(negedge clk) #1 check("r0_again", 64'(grant), 64'b01);

      // Reset mid-session with r1 pending.
      @(negedge clk) req_start = 2'b10;
      @(negedge clk) begin req_start = 2'b00; rst = 1'b1; end
      @(negedge clk) rst = 1'b0;
      #1;
      check("mid_rst_grant", 64'(grant), 64'd0);
      check("mid_rst_start", 64'(hash_start), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) #1 check("no_stale_grant", 64'(grant), 64'd0);
      end

      // Random traffic against the model.
      rst = 1'b1;
      @(posedge clk) model_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst           = ($urandom_range(0, 299) == 0);
         req_start     = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         req_in_len    = {$urandom, $urandom};
         req_out_len   = {$urandom, $urandom};
         req_data_in   = {$urandom, $urandom};
         req_ready     = 2'($urandom);
         req_fd        = 2'($urandom);
         core_addr     = 4'($urandom);
         core_rd_en    = 1'($urandom);
         core_data_out = $urandom;
         core_valid    = 1'($urandom);
         core_ack      = ($urandom_range(0, 5) == 0);
         #1 model_compare();
         @(posedge clk) model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
